// File: rtl/router_fifo.sv
// Per-destination packet FIFO of the 1x3 router: data_out is registered one clock after a read edge.
// Writes while full and reads while empty are dropped; data_out blanks to zero between packets.
module router_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  typedef logic [WIDTH:0] word_t;

  word_t            mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [6:0]       pkt_cnt_q, pkt_cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             wr_ok;
  logic             rd_ok;
  word_t            rd_word;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_ok    = write_enb & ~full;
  assign rd_ok    = read_enb & ~empty;
  assign rd_word  = mem_q[rd_ptr_q[AW-1:0]];
  assign data_out = data_out_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, wr_ok};
    rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, rd_ok};
    pkt_cnt_d  = pkt_cnt_q;
    data_out_d = data_out_q;
    if (rd_ok) begin
      data_out_d = rd_word[WIDTH-1:0];
      // Header length field excludes the header; +1 covers the trailing parity byte.
      if (rd_word[WIDTH]) begin
        pkt_cnt_d = 7'(rd_word[WIDTH-1:2]) + 7'd1;
      end else if (pkt_cnt_q != '0) begin
        pkt_cnt_d = pkt_cnt_q - 7'd1;
      end
    end else if (pkt_cnt_q == '0) begin
      data_out_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn || soft_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pkt_cnt_q  <= '0;
      data_out_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      data_out_q <= data_out_d;
      if (wr_ok) begin
        mem_q[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
      end
    end
  end

  a_not_full_and_empty: assert property (@(posedge clock) disable iff (!resetn)
    !(full && empty));

  a_depth_matches_aw: assert property (@(posedge clock) DEPTH == (1 << AW));

endmodule
